// File: rtl/px_ser_pkg.sv
// px_ser_pkg: shared types and constants for the pixel output serializer.
//   state_t   : serializer FSM states (IDLE, SEND)
//   nchunk()  : number of CHUNK_BITS-wide chunks needed to carry one pixel
//   DEF_*     : default parameter values used by px_fifo and px_out_serializer
package px_ser_pkg;

    localparam int DEF_PIXEL_BITS = 24;
    localparam int DEF_CHUNK_BITS = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ceil(pixel_bits / chunk_bits)
    function automatic int nchunk(input int pixel_bits, input int chunk_bits);
        return (pixel_bits + chunk_bits - 1) / chunk_bits;
    endfunction

endpackage

// File: rtl/px_fifo.sv
// px_fifo: synchronous pixel FIFO with first-word fall-through read data.
// Ports:
//   clk_i     in   clock, rising edge
//   nreset_i  in   synchronous active-low reset
//   flush_i   in   synchronous clear; overrides push and pop
//   push_i    in   write data_i this cycle (ignored while full)
//   data_i    in   WIDTH  write data
//   pop_i     in   drop the head entry this cycle (ignored while empty)
//   data_o    out  WIDTH  head entry, valid while count_o != 0
//   full_o    out  count_o == DEPTH
//   count_o   out  number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module px_fifo
    import px_ser_pkg::*;
#(
    parameter int WIDTH = DEF_PIXEL_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    // Full and empty come from the registered count only, so a pop in the
    // same cycle never makes room for a push into a full FIFO.
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    // NOTE: every variable gets its default before any branch; a path that
    // leaves a combinational output unassigned would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, so clearing it would be dead logic.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/px_out_serializer.sv
// px_out_serializer: buffers processed pixels and streams each one out as
// NCHUNK chunks of CHUNK_BITS, least-significant chunk first, over a
// valid/ready handshake. The top chunk is zero-padded above PIXEL_BITS.
// Ports:
//   clk_i          in   clock, rising edge
//   nreset_i       in   synchronous active-low reset
//   px_valid_i     in   one-cycle strobe: px_data_i holds a new pixel
//   px_data_i      in   PIXEL_BITS pixel value
//   flush_i        in   synchronous clear of FIFO, FSM and overflow flag
//   chunk_o        out  CHUNK_BITS current chunk (0 when not valid)
//   chunk_valid_o  out  chunk_o valid
//   chunk_ready_i  in   sink accepts the chunk when valid & ready
//   first_o        out  chunk_o is chunk 0 of a pixel
//   fifo_full_o    out  FIFO holds FIFO_DEPTH entries
//   overflow_o     out  sticky: a pixel arrived while the FIFO was full
//   parity_o       out  XOR of chunk_o (only with PX_SER_PARITY_EN defined)
// Optional feature macro: PX_SER_PARITY_EN.
// All outputs decode registered state only; chunk_ready_i reaches no output
// combinationally.
module px_out_serializer
    import px_ser_pkg::*;
#(
    parameter int PIXEL_BITS = DEF_PIXEL_BITS,
    parameter int CHUNK_BITS = DEF_CHUNK_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  px_valid_i,
    input  logic [PIXEL_BITS-1:0] px_data_i,
    input  logic                  flush_i,
    output logic [CHUNK_BITS-1:0] chunk_o,
    output logic                  chunk_valid_o,
    input  logic                  chunk_ready_i,
    output logic                  first_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o
`ifdef PX_SER_PARITY_EN
    ,
    output logic                  parity_o
`endif
);

    localparam int NCHUNK = nchunk(PIXEL_BITS, CHUNK_BITS);
    localparam int SHW    = NCHUNK * CHUNK_BITS;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);
    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

    state_t          state_q, state_d;
    logic [SHW-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            overflow_q, overflow_d;

    logic                  fifo_pop;
    logic [PIXEL_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_empty;
    logic [SHW-1:0]        shreg_load;

    px_fifo #(
        .WIDTH (PIXEL_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .flush_i  (flush_i),
        .push_i   (px_valid_i),
        .data_i   (px_data_i),
        .pop_i    (fifo_pop),
        .data_o   (fifo_head),
        .full_o   (fifo_full),
        .count_o  (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);

    // Head pixel widened to whole chunks; the padding bits are zero.
    always_comb begin
        shreg_load = '0;
        shreg_load[PIXEL_BITS-1:0] = fifo_head;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;
        if (flush_i) begin
            state_d    = IDLE;
            shreg_d    = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (px_valid_i && fifo_full) overflow_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = shreg_load;
                        cnt_d    = '0;
                        state_d  = SEND;
                    end
                end
                SEND: begin
                    if (chunk_ready_i) begin
                        if (cnt_q != LAST_CNT) begin
                            shreg_d = shreg_q >> CHUNK_BITS;
                            cnt_d   = cnt_q + CW'(1);
                        end else if (!fifo_empty) begin
                            // Last chunk accepted with a pixel waiting:
                            // reload directly so there is no idle bubble.
                            fifo_pop = 1'b1;
                            shreg_d  = shreg_load;
                            cnt_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign chunk_valid_o = (state_q == SEND);
    assign chunk_o       = chunk_valid_o ? shreg_q[CHUNK_BITS-1:0] : '0;
    assign first_o       = chunk_valid_o && (cnt_q == '0);
    assign fifo_full_o   = fifo_full;
    assign overflow_o    = overflow_q;

`ifdef PX_SER_PARITY_EN
    // chunk_o is already forced to 0 outside SEND, so parity follows it.
    assign parity_o = ^chunk_o;
`endif

endmodule

// File: tb/tb_px_out_serializer.sv
// tb_px_out_serializer: scoreboard bench for px_out_serializer.
// Stimulus pushes the chunk sequence each accepted pixel must produce into a
// queue; a negedge monitor pops and compares on every valid&ready handshake
// and checks that a stalled chunk is held stable.
module tb_px_out_serializer;

    localparam int PIXEL_BITS = 24;
    localparam int CHUNK_BITS = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int NCHUNK     = (PIXEL_BITS + CHUNK_BITS - 1) / CHUNK_BITS;

    logic                  clk_i = 1'b0;
    logic                  nreset_i;
    logic                  px_valid_i;
    logic [PIXEL_BITS-1:0] px_data_i;
    logic                  flush_i;
    logic [CHUNK_BITS-1:0] chunk_o;
    logic                  chunk_valid_o;
    logic                  chunk_ready_i;
    logic                  first_o;
    logic                  fifo_full_o;
    logic                  overflow_o;
`ifdef PX_SER_PARITY_EN
    logic                  parity_o;
`endif

    always #5 clk_i = ~clk_i;

    px_out_serializer #(
        .PIXEL_BITS (PIXEL_BITS),
        .CHUNK_BITS (CHUNK_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .nreset_i      (nreset_i),
        .px_valid_i    (px_valid_i),
        .px_data_i     (px_data_i),
        .flush_i       (flush_i),
        .chunk_o       (chunk_o),
        .chunk_valid_o (chunk_valid_o),
        .chunk_ready_i (chunk_ready_i),
        .first_o       (first_o),
        .fifo_full_o   (fifo_full_o),
        .overflow_o    (overflow_o)
`ifdef PX_SER_PARITY_EN
        ,
        .parity_o      (parity_o)
`endif
    );

    typedef struct packed {
        logic [CHUNK_BITS-1:0] data;
        logic                  first;
        logic                  last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted_px = 0;  // written by stimulus only
    int   done_px = 0;      // written by monitor only

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a pixel is NCHUNK slices of its zero-extended value, LS first.
    task automatic expect_pixel(input logic [PIXEL_BITS-1:0] px);
        logic [NCHUNK*CHUNK_BITS-1:0] wide;
        exp_t e;
        wide = '0;
        wide[PIXEL_BITS-1:0] = px;
        for (int k = 0; k < NCHUNK; k++) begin
            e.data  = wide[k*CHUNK_BITS +: CHUNK_BITS];
            e.first = (k == 0);
            e.last  = (k == NCHUNK - 1);
            exp_q.push_back(e);
        end
        accepted_px++;
    endtask

    // Everything the DUT was going to send is abandoned (reset or flush).
    task automatic clear_model();
        exp_q.delete();
        accepted_px = done_px;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_px(input logic [PIXEL_BITS-1:0] px, input bit accept);
        px_valid_i = 1'b1;
        px_data_i  = px;
        step();
        px_valid_i = 1'b0;
        if (accept) expect_pixel(px);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!chunk_valid_o && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(chunk_valid_o), 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        chunk_ready_i = 1'b1;
        while ((exp_q.size() != 0 || chunk_valid_o) && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(chunk_valid_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    32'(chunk_valid_o), 32'd0);
        check({tag, "_chunk"},    32'(chunk_o),       32'd0);
        check({tag, "_first"},    32'(first_o),       32'd0);
        check({tag, "_full"},     32'(fifo_full_o),   32'd0);
        check({tag, "_overflow"}, 32'(overflow_o),    32'd0);
`ifdef PX_SER_PARITY_EN
        check({tag, "_parity"},   32'(parity_o),      32'd0);
`endif
    endtask

    // Monitor: values at the negedge are those the next rising edge samples.
    logic                  stall_seen = 1'b0;
    logic [CHUNK_BITS-1:0] stall_chunk;
    logic                  stall_first;

    always @(negedge clk_i) begin
        exp_t e;
        if (stall_seen) begin
            check("stall_valid", 32'(chunk_valid_o), 32'd1);
            check("stall_chunk", 32'(chunk_o),       32'(stall_chunk));
            check("stall_first", 32'(first_o),       32'(stall_first));
        end
        stall_seen  = nreset_i && !flush_i && chunk_valid_o && !chunk_ready_i;
        stall_chunk = chunk_o;
        stall_first = first_o;
        if (chunk_valid_o === 1'b1 && chunk_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_chunk: got %0h expected no chunk", chunk_o);
            end else begin
                e = exp_q.pop_front();
                check("chunk_data",  32'(chunk_o), 32'(e.data));
                check("chunk_first", 32'(first_o), 32'(e.first));
`ifdef PX_SER_PARITY_EN
                check("chunk_parity", 32'(parity_o), 32'(^e.data));
`endif
                if (e.last) done_px++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PIXEL_BITS-1:0] px;
        nreset_i      = 1'b0;
        px_valid_i    = 1'b0;
        px_data_i     = '0;
        flush_i       = 1'b0;
        chunk_ready_i = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        nreset_i = 1'b1;
        step();

        // Single pixel, ready high: chunk 0 visible one edge after the push edge.
        chunk_ready_i = 1'b1;
        push_px(24'hA1B2C3, 1'b1);
        check("lat_not_yet", 32'(chunk_valid_o), 32'd0);
        step();
        check("lat_valid", 32'(chunk_valid_o), 32'd1);
        check("lat_chunk", 32'(chunk_o),       32'hC3);
        check("lat_first", 32'(first_o),       32'd1);
        drain("t1_drain", 20);

        // Two pixels back-to-back: six consecutive valid cycles, no bubble.
        push_px(24'h112233, 1'b1);
        push_px(24'h445566, 1'b1);
        wait_valid("t2_wait", 10);
        for (int i = 0; i < 2 * NCHUNK; i++) begin
            check("t2_no_gap", 32'(chunk_valid_o), 32'd1);
            step();
        end
        drain("t2_drain", 20);

        // Stall: chunk held while ready is low.
        chunk_ready_i = 1'b0;
        push_px(24'h0000FF, 1'b1);
        wait_valid("t3_wait", 10);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", 32'(chunk_o), 32'hFF);
            step();
        end
        drain("t3_drain", 20);

        // Overflow: with ready low the first pixel moves into the shift
        // register, so FIFO_DEPTH+1 back-to-back pixels fit and the next drops.
        chunk_ready_i = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            push_px(24'h100000 + 24'(i), (i < FIFO_DEPTH + 1));
            if (i == FIFO_DEPTH - 1) check("t4_not_full", 32'(fifo_full_o), 32'd0);
            if (i == FIFO_DEPTH) begin
                check("t4_full",       32'(fifo_full_o), 32'd1);
                check("t4_no_ovf_yet", 32'(overflow_o),  32'd0);
            end
        end
        check("t4_overflow", 32'(overflow_o), 32'd1);
        drain("t4_drain", 60);
        check("t4_sticky", 32'(overflow_o), 32'd1);
        check("t4_drained_full", 32'(fifo_full_o), 32'd0);

        // Flush with a simultaneous push while overflow is set and pixels pending.
        chunk_ready_i = 1'b0;
        push_px(24'h777777, 1'b1);
        push_px(24'h888888, 1'b1);
        push_px(24'h999999, 1'b1);
        flush_i    = 1'b1;
        px_valid_i = 1'b1;
        px_data_i  = 24'hDEADBE;
        step();
        flush_i    = 1'b0;
        px_valid_i = 1'b0;
        clear_model();
        check("t6_overflow", 32'(overflow_o),    32'd0);
        check("t6_full",     32'(fifo_full_o),   32'd0);
        check("t6_valid",    32'(chunk_valid_o), 32'd0);
        chunk_ready_i = 1'b1;
        repeat (3) step();
        check("t6_discarded", 32'(chunk_valid_o), 32'd0);

        // Reset after chunk 0 is accepted aborts the pixel.
        chunk_ready_i = 1'b1;
        push_px(24'h5A6B7C, 1'b1);
        wait_valid("t5_wait", 10);
        nreset_i = 1'b0;
        step();
        clear_model();
        check_all_zero("t5_reset");
        nreset_i = 1'b1;
        step();
        push_px(24'h0C0B0A, 1'b1);
        step();
        check("t5_restart_first", 32'(first_o), 32'd1);
        check("t5_restart_chunk", 32'(chunk_o), 32'h0A);
        drain("t5_drain", 20);

`ifdef PX_SER_PARITY_EN
        chunk_ready_i = 1'b0;
        push_px(24'h000307, 1'b1);
        wait_valid("par_wait", 10);
        check("par_07", 32'(parity_o), 32'd1);
        chunk_ready_i = 1'b1;
        step();
        check("par_03_chunk", 32'(chunk_o),  32'h03);
        check("par_03",       32'(parity_o), 32'd0);
        drain("par_drain", 20);
`endif

        // Random traffic, never more than FIFO_DEPTH pixels in flight so
        // no pixel can be dropped.
        for (int c = 0; c < 400; c++) begin
            chunk_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && (accepted_px - done_px) < FIFO_DEPTH) begin
                px = PIXEL_BITS'($urandom);
                push_px(px, 1'b1);
            end else begin
                step();
            end
        end
        drain("rand_drain", 200);
        check("rand_no_overflow", 32'(overflow_o), 32'd0);
        check("rand_all_done", 32'(done_px), 32'(accepted_px));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
